// File: rtl/branch_resolve.sv
// branch_resolve: checks resolved branches against the fetch prediction,
// issues a fetch redirect plus one-cycle flush on a mispredict, and counts
// accepted branches and mispredicts.
// Ports: clk/reset (sync, active-high); ex_* resolution in (ex_ready back);
// redirect_valid/redirect_pc/redirect_ready to fetch; flush to IF/ID;
// cnt_branch/cnt_mispred are 64-bit event counters.
module branch_resolve (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [63:0] ex_pc,
  input  logic [63:0] ex_pred_pc,
  input  logic        ex_taken,
  input  logic [63:0] ex_target,
  output logic        ex_ready,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        flush,
  output logic [63:0] cnt_branch,
  output logic [63:0] cnt_mispred
);

  typedef enum logic {
    IDLE,
    REDIRECT
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        accept;
  logic        is_br;
  logic        mispred;
  logic [63:0] correct_pc;
  logic        flush_q;

  assign ex_ready       = (state == IDLE);
  assign redirect_valid = (state == REDIRECT);
  assign flush          = flush_q;

  assign accept     = ex_valid && ex_ready;
  assign is_br      = accept && ex_is_branch;
  assign correct_pc = ex_taken ? ex_target
                               : ex_pc + 64'd4;
  assign mispred    = is_br &&
                      (correct_pc != ex_pred_pc);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (mispred) state_nx = REDIRECT;
      REDIRECT:
        if (redirect_ready) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      flush_q     <= 1'b0;
      redirect_pc <= '0;
      cnt_branch  <= '0;
      cnt_mispred <= '0;
    end else begin
      state   <= state_nx;
      // flush marks only the first REDIRECT cycle
      flush_q <= mispred;
      if (mispred)
        redirect_pc <= correct_pc;
      if (is_br)
        cnt_branch <= cnt_branch + 64'd1;
      if (mispred)
        cnt_mispred <= cnt_mispred + 64'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed scenarios then random traffic, all checked
// against a behavioural model of the branch resolver.
module tb_branch_resolve;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [63:0] ex_pc;
  logic [63:0] ex_pred_pc;
  logic        ex_taken;
  logic [63:0] ex_target;
  logic        ex_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        redirect_ready;
  logic        flush;
  logic [63:0] cnt_branch;
  logic [63:0] cnt_mispred;

  int total;
  int bad;

  bit          m_redir;
  int          m_age;
  logic [63:0] m_rpc;
  logic [63:0] m_cb;
  logic [63:0] m_cm;

  branch_resolve dut (
    .clk            (clk),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_pred_pc     (ex_pred_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_ready       (ex_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .flush          (flush),
    .cnt_branch     (cnt_branch),
    .cnt_mispred    (cnt_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input bit br,
                       input logic [63:0] pc,
                       input logic [63:0] pred,
                       input bit tk,
                       input logic [63:0] tgt);
    ex_valid     = v;
    ex_is_branch = br;
    ex_pc        = pc;
    ex_pred_pc   = pred;
    ex_taken     = tk;
    ex_target    = tgt;
  endtask

  // Model: what the spec says happens at one rising edge.
  task automatic model_edge();
    logic [63:0] cpc;
    if (reset) begin
      m_redir = 0;
      m_age   = 0;
      m_rpc   = '0;
      m_cb    = '0;
      m_cm    = '0;
    end else if (!m_redir) begin
      if (ex_valid && ex_is_branch) begin
        m_cb = m_cb + 1;
        cpc = ex_taken ? ex_target : ex_pc + 4;
        if (cpc != ex_pred_pc) begin
          m_cm    = m_cm + 1;
          m_redir = 1;
          m_age   = 0;
          m_rpc   = cpc;
        end
      end
    end else begin
      if (redirect_ready) m_redir = 0;
      else m_age++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ex_ready"}, 64'(ex_ready),
        64'(!m_redir));
    chk({tag, ".rv"}, 64'(redirect_valid),
        64'(m_redir));
    chk({tag, ".flush"}, 64'(flush),
        64'(m_redir && m_age == 0));
    chk({tag, ".rpc"}, redirect_pc, m_rpc);
    chk({tag, ".cb"}, cnt_branch, m_cb);
    chk({tag, ".cm"}, cnt_mispred, m_cm);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [63:0] pc, tgt, pred, cpc;
    bit tk;
    total = 0;
    bad   = 0;
    m_redir = 0; m_age = 0;
    m_rpc = '0; m_cb = '0; m_cm = '0;
    reset = 1'b1;
    redirect_ready = 1'b0;
    drive(1, 1, 64'h10, 64'h0, 0, 64'h0);
    step("rst0");
    step("rst1");
    chk("rst.cb", cnt_branch, 64'd0);
    reset = 1'b0;

    // correct taken branch
    drive(1, 1, 64'h1000, 64'h0F00, 1, 64'h0F00);
    step("c34");
    chk("c34.cb_abs", cnt_branch, 64'd1);
    chk("c34.cm_abs", cnt_mispred, 64'd0);
    drive(1, 1, 64'h1004, 64'h1008, 0, 64'h0);
    step("c34b2b");

    // not-taken mispredict with stalled fetch
    drive(1, 1, 64'h2000, 64'h1F00, 0, 64'h0);
    step("m35a");
    chk("m35.rpc_abs", redirect_pc, 64'h2004);
    chk("m35.flush_abs", 64'(flush), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 1, 64'h5000, 64'h0, 1, 64'h7);
      step("m35hold");
    end
    redirect_ready = 1'b1;
    drive(0, 0, 64'h0, 64'h0, 0, 64'h0);
    step("m35rel");
    chk("m35.cm_abs", cnt_mispred, 64'd1);

    // same-cycle ready, taken mispredict
    drive(1, 1, 64'h3000, 64'h3004, 1, 64'h4000);
    step("m36a");
    chk("m36.rpc_abs", redirect_pc, 64'h4000);
    drive(0, 0, 64'h0, 64'h0, 0, 64'h0);
    step("m36b");
    chk("m36.rdy_abs", 64'(ex_ready), 64'd1);

    // pc+4 wrap
    drive(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 0, 64'h0);
    step("w37a");
    drive(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 0, 64'h0);
    step("w37b");
    chk("w37.rpc_abs", redirect_pc, 64'h0);
    drive(0, 0, 64'h0, 64'h0, 0, 64'h0);
    step("w37c");

    // reset while redirecting
    redirect_ready = 1'b0;
    drive(1, 1, 64'h6000, 64'h0, 0, 64'h0);
    step("r38a");
    reset = 1'b1;
    step("r38rst");
    reset = 1'b0;
    drive(0, 0, 64'h0, 64'h0, 0, 64'h0);
    step("r38rel");
    chk("r38.cb_abs", cnt_branch, 64'd0);

    // 100 non-branches, 10 branches, 3 mispredicted
    redirect_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(1, 0, 64'(i * 4), 64'h0, 0, 64'h0);
      step("n39");
    end
    for (int i = 0; i < 10; i++) begin
      pc = 64'h8000 + 64'(i * 16);
      drive(1, 1, pc, (i < 3) ? pc : pc + 4, 0, 64'h0);
      step("b39");
      if (i < 3) begin
        drive(0, 0, 64'h0, 64'h0, 0, 64'h0);
        step("b39r");
      end
    end
    chk("c39.cb_abs", cnt_branch, 64'd10);
    chk("c39.cm_abs", cnt_mispred, 64'd3);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      redirect_ready = $urandom_range(0, 1) == 1;
      pc  = {$urandom, $urandom} & ~64'h3;
      tgt = {$urandom, $urandom} & ~64'h3;
      tk  = $urandom_range(0, 1) == 1;
      cpc = tk ? tgt : pc + 4;
      pred = ($urandom_range(0, 2) != 0) ? cpc
             : {$urandom, $urandom};
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0,
            pc, pred, tk, tgt);
      step("rnd");
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
